// File: rtl/pipe_skid_reg_if.sv
// Valid/ready stream bundle used on both sides of the elastic pipeline register.
// The master drives valid and data, and the slave drives ready.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic two-entry pipeline register (main + skid) sitting between CPU stages.
// in_ready is decoded from the state flop only. This keeps out_ready off the
// combinational path to in_ready while still sustaining one item per cycle.
// A synchronous flush drops every held and incoming item and loads the bubble value.
module pipe_skid_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    pipe_skid_reg_if.slave        in_if,
    pipe_skid_reg_if.master       out_if,
    output logic [1:0]            count
);

    // EMPTY: nothing held; BUSY: main valid; FULL: main (older) + skid (younger) valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;

    assign in_ready     = (state_q != FULL);
    assign out_valid    = (state_q != EMPTY);
    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;

    assign in_fire  = in_if.valid & in_ready;
    assign out_fire = out_valid & out_if.ready;

    // Occupancy decoded from the state flop
    always_comb begin
        count = 2'd0;
        unique case (state_q)
            EMPTY:   count = 2'd0;
            BUSY:    count = 2'd1;
            FULL:    count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    // Next-state and data steering; flush overrides every transfer in its cycle
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = CLR_VAL;
            skid_d  = CLR_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_if.data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_if.data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_if.data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and payload registers with asynchronous reset to the bubble value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= CLR_VAL;
            skid_q  <= CLR_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
